// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM memory-stage controller.
// Holds the FSM state encoding, default parameter values and the phase counter width.
// No logic lives here.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_ADDR_BASE   = 1024;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned DEFAULT_SRAM_AW     = 18;

  // Wait states are limited to 0..7, so the phase counter never needs more than 3 bits.
  localparam int unsigned CNT_W = $clog2(8);

endpackage

// File: rtl/sram_wait_counter.sv
// Phase-cycle counter shared by the LOW and HIGH half-word phases.
// Counts 0..MAX while enabled; last_o flags the terminal (final) cycle of a phase.
// Clear has priority over enable so each phase starts from zero.
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned MAX = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step while a phase is active.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/sram_mem_controller.sv
// Sequences a 32-bit load/store as two 16-bit async SRAM accesses (LOW then HIGH half).
// Latency: request in IDLE at cycle 0, DONE at cycle 2*WAIT_CYCLES+3.
// Backpressure: stall held high (combinationally) from request until DONE; requests ignored in DONE.
module sram_mem_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_En,
  input  logic               MEM_W_En,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  state_e state_q;
  state_e state_d;

  logic               is_wr_q;
  logic [SRAM_AW-2:0] w_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [SRAM_AW-1:0] sram_addr_q;

  logic        req;
  logic        in_phase;
  logic        last;
  logic        start;
  logic [31:0] offset;
  logic [SRAM_AW-2:0] w_next;
  logic        unused_offset_bits;

  assign req      = MEM_R_En | MEM_W_En;
  assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign start    = (state_q == ST_IDLE) && req;

  // Word index relative to the mapped base; upper bits wrap silently.
  assign offset = address - 32'(ADDR_BASE);
  assign w_next = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // One counter serves both phases: it runs only inside a phase and restarts
  // after the terminal cycle, so the next phase always begins at zero.
  sram_wait_counter #(
    .MAX (WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!in_phase || last),
    .en_i   (in_phase),
    .last_o (last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and SRAM strobe/enable decode.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = (state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
    unique case (state_q)
      ST_IDLE: begin
        stall = req;
        if (req) state_d = ST_LOW;
      end
      ST_LOW: begin
        stall = 1'b1;
        if (last) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        stall = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (in_phase) begin
      sram_oe_n  = is_wr_q;
      sram_dq_oe = is_wr_q;
      // Final cycle of a write phase is the data hold cycle, except with no
      // wait states where the single cycle must carry the strobe.
      sram_we_n  = !(is_wr_q && (!last || (WAIT_CYCLES == 0)));
    end
    if (rst) stall = 1'b0;
  end

  // Access context latch, half-word address sequencing and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr_q     <= 1'b0;
      w_q         <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      if (start) begin
        // A write wins when both enables are set.
        is_wr_q     <= MEM_W_En;
        w_q         <= w_next;
        wdata_q     <= wdata;
        sram_addr_q <= {w_next, 1'b0};
      end
      if ((state_q == ST_LOW) && last) begin
        sram_addr_q <= {w_q, 1'b1};
        if (!is_wr_q) rdata_q[15:0] <= sram_dq_in;
      end
      if ((state_q == ST_HIGH) && last && !is_wr_q) begin
        rdata_q[31:16] <= sram_dq_in;
      end
    end
  end

  assign rdata     = rdata_q;
  assign sram_addr = sram_addr_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench: default-parameter controller plus a zero-wait-state instance,
// each attached to a small behavioural async SRAM preloaded with 16'h1000+index.
// Expected values are hand-computed constants.
module tb_sram_mem_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_mem = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- WAIT_CYCLES = 2 instance ----------------
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic [31:0] rdata;
  logic        stall;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe, we_n, oe_n;
  logic [15:0] mem [0:255];

  sram_mem_controller dut (
    .clk(clk), .rst(rst), .MEM_R_En(r_en), .MEM_W_En(w_en),
    .address(addr_in), .wdata(wdata_in), .rdata(rdata), .stall(stall),
    .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_oe(dq_oe),
    .sram_dq_in(dq_in), .sram_we_n(we_n), .sram_oe_n(oe_n)
  );

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (!we_n) begin
      mem[sram_addr[7:0]] <= dq_out;
    end
  end
  assign dq_in = oe_n ? 16'h0000 : mem[sram_addr[7:0]];

  // ---------------- WAIT_CYCLES = 0 instance ----------------
  logic        r_en0 = 1'b0, w_en0 = 1'b0;
  logic [31:0] addr_in0 = '0, wdata_in0 = '0;
  logic [31:0] rdata0;
  logic        stall0;
  logic [17:0] sram_addr0;
  logic [15:0] dq_out0, dq_in0;
  logic        dq_oe0, we_n0, oe_n0;
  logic [15:0] mem0 [0:255];

  sram_mem_controller #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_En(r_en0), .MEM_W_En(w_en0),
    .address(addr_in0), .wdata(wdata_in0), .rdata(rdata0), .stall(stall0),
    .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_oe(dq_oe0),
    .sram_dq_in(dq_in0), .sram_we_n(we_n0), .sram_oe_n(oe_n0)
  );

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 16'h1000 + 16'(i);
    end else if (!we_n0) begin
      mem0[sram_addr0[7:0]] <= dq_out0;
    end
  end
  assign dq_in0 = oe_n0 ? 16'h0000 : mem0[sram_addr0[7:0]];

  // Stimulus driver: called at a negedge in IDLE. Applies the request, counts
  // stalled cycles and write-strobe cycles, returns in the first unstalled
  // cycle (DONE). Optionally drops the request at cycle drop_at.
  task automatic run_access(input bit sel, input bit r, input bit w,
                            input logic [31:0] a, input logic [31:0] d,
                            input int drop_at,
                            output int n_stall, output int n_we, output bit done_ok);
    if (sel) begin r_en0 = r; w_en0 = w; addr_in0 = a; wdata_in0 = d; end
    else     begin r_en  = r; w_en  = w; addr_in  = a; wdata_in  = d; end
    #1;
    n_stall = 0; n_we = 0; done_ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == drop_at) begin
        if (sel) begin r_en0 = 1'b0; w_en0 = 1'b0; end
        else     begin r_en  = 1'b0; w_en  = 1'b0; end
        #1;
      end
      if (sel ? stall0 : stall) begin
        n_stall++;
        if (!(sel ? we_n0 : we_n)) n_we++;
      end else begin
        done_ok = (c > 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic clear_req();
    r_en = 1'b0; w_en = 1'b0; r_en0 = 1'b0; w_en0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata); end
    vectors++; if (sram_addr !== 18'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    vectors++; if (dq_out !== 16'h0) begin miscompares++; $display("FAIL reset_dq_out got %h want 0", dq_out); end
    vectors++; if ({dq_oe, we_n, oe_n} !== 3'b011) begin miscompares++; $display("FAIL reset_ctl got %b want 011", {dq_oe, we_n, oe_n}); end
    vectors++; if ({stall0, dq_oe0, we_n0, oe_n0} !== 4'b0011 || sram_addr0 !== 18'h0) begin
      miscompares++; $display("FAIL reset_dut0 got ctl %b addr %h want 0011 addr 0", {stall0, dq_oe0, we_n0, oe_n0}, sram_addr0); end
  endtask

  task automatic test_store_load();
    int ns, nw; bit ok;
    run_access(1'b0, 1'b0, 1'b1, 32'h400, 32'hDEADBEEF, -1, ns, nw, ok);
    vectors++; if (!ok || ns != 7) begin miscompares++; $display("FAIL store_stall got %0d done %0b want 7 done 1", ns, ok); end
    clear_req();
    vectors++; if (mem[0] !== 16'hBEEF) begin miscompares++; $display("FAIL store_low got %h want beef", mem[0]); end
    vectors++; if (mem[1] !== 16'hDEAD) begin miscompares++; $display("FAIL store_high got %h want dead", mem[1]); end
    run_access(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, -1, ns, nw, ok);
    vectors++; if (!ok || ns != 7) begin miscompares++; $display("FAIL load_stall got %0d done %0b want 7 done 1", ns, ok); end
    vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_rdata got %h want deadbeef", rdata); end
    vectors++; if (nw != 0) begin miscompares++; $display("FAIL load_no_we got %0d want 0", nw); end
    clear_req();
  endtask

  task automatic test_addr_map();
    int ns, nw; bit ok;
    run_access(1'b0, 1'b0, 1'b1, 32'h40C, 32'h12345678, -1, ns, nw, ok);
    vectors++; if (nw != 4) begin miscompares++; $display("FAIL map_we_cycles got %0d want 4", nw); end
    clear_req();
    vectors++; if (mem[6] !== 16'h5678 || mem[7] !== 16'h1234) begin
      miscompares++; $display("FAIL map_data got %h %h want 5678 1234", mem[6], mem[7]); end
    vectors++; if (mem[5] !== 16'h1005 || mem[8] !== 16'h1008) begin
      miscompares++; $display("FAIL map_neighbours got %h %h want 1005 1008", mem[5], mem[8]); end
  endtask

  task automatic test_back_to_back();
    int ns, nw; bit ok;
    run_access(1'b0, 1'b0, 1'b1, 32'h408, 32'hCAFEF00D, -1, ns, nw, ok);
    w_en = 1'b0; r_en = 1'b1; addr_in = 32'h404; #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL b2b_done_stall got %b want 0", stall); end
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_stall got %b want 1", stall); end
    run_access(1'b0, 1'b1, 1'b0, 32'h404, 32'h0, -1, ns, nw, ok);
    vectors++; if (!ok || ns != 7) begin miscompares++; $display("FAIL b2b_load_stall got %0d want 7", ns); end
    vectors++; if (rdata !== 32'h10031002) begin miscompares++; $display("FAIL b2b_rdata got %h want 10031002", rdata); end
    clear_req();
    vectors++; if (mem[4] !== 16'hF00D || mem[5] !== 16'hCAFE) begin
      miscompares++; $display("FAIL b2b_store got %h %h want f00d cafe", mem[4], mem[5]); end
  endtask

  task automatic test_flush();
    int ns, nw; bit ok;
    run_access(1'b0, 1'b0, 1'b1, 32'h410, 32'h0BADC0DE, 2, ns, nw, ok);
    vectors++; if (!ok || ns != 7) begin miscompares++; $display("FAIL flush_done got %0d done %0b want 7 done 1", ns, ok); end
    vectors++; if (nw != 4) begin miscompares++; $display("FAIL flush_we_cycles got %0d want 4", nw); end
    clear_req();
    vectors++; if (mem[8] !== 16'hC0DE || mem[9] !== 16'h0BAD) begin
      miscompares++; $display("FAIL flush_data got %h %h want c0de 0bad", mem[8], mem[9]); end
  endtask

  task automatic test_reset_mid();
    r_en = 1'b1; addr_in = 32'h400;
    for (int c = 0; c < 4; c++) @(negedge clk);
    vectors++; if (sram_addr !== 18'h1 || stall !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset got addr %h stall %b want 1 1", sram_addr, stall); end
    rst = 1'b1; #1;
    vectors++; if (stall !== 1'b0 || {dq_oe, we_n, oe_n} !== 3'b011) begin
      miscompares++; $display("FAIL midrst_ctl got stall %b ctl %b want 0 011", stall, {dq_oe, we_n, oe_n}); end
    vectors++; if (sram_addr !== 18'h0 || rdata !== 32'h0 || dq_out !== 16'h0) begin
      miscompares++; $display("FAIL midrst_regs got addr %h rdata %h dq %h want 0 0 0", sram_addr, rdata, dq_out); end
    r_en = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vectors++; if (stall !== 1'b0 || oe_n !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_idle got stall %b oe_n %b want 0 1", stall, oe_n); end
  endtask

  task automatic test_both_enables();
    int ns, nw; bit ok;
    run_access(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, -1, ns, nw, ok);
    vectors++; if (!ok || ns != 3 || rdata0 !== 32'h10011000) begin
      miscompares++; $display("FAIL w0_load got stall %0d rdata %h want 3 10011000", ns, rdata0); end
    clear_req();
    run_access(1'b1, 1'b1, 1'b1, 32'h414, 32'h55AA33CC, -1, ns, nw, ok);
    vectors++; if (!ok || ns != 3) begin miscompares++; $display("FAIL both_stall got %0d want 3", ns); end
    vectors++; if (nw != 2) begin miscompares++; $display("FAIL both_we_cycles got %0d want 2", nw); end
    vectors++; if (rdata0 !== 32'h10011000) begin miscompares++; $display("FAIL both_rdata got %h want 10011000", rdata0); end
    clear_req();
    vectors++; if (mem0[10] !== 16'h33CC || mem0[11] !== 16'h55AA) begin
      miscompares++; $display("FAIL both_data got %h %h want 33cc 55aa", mem0[10], mem0[11]); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0; init_mem = 1'b0;
    @(negedge clk);
    test_store_load();
    test_addr_map();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_both_enables();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Memory-stage controller that sequences a 32-bit load/store from the pipeline onto an external 16-bit asynchronous SRAM as two half-word accesses with programmable wait states. While an access is in flight it drives `stall` to freeze the IF/ID/EXE/MEM pipeline registers. It sits between the EXE→MEM pipeline register outputs (`MEM_R_En`, `MEM_W_En`, `ALU_result`, store data) and the MEM→WB register.

## Interface
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, default 2: extra cycles per half-word phase. Legal range 0–7.
- `SRAM_AW`, default 18: SRAM address width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `MEM_R_En`  in  1: load request, level, held by the stalled pipeline.
- `MEM_W_En`  in  1: store request, level.
- `address`  in  32: byte address, i.e. `ALU_result`.
- `wdata`  in  32: store data.
- `rdata`  out  32: load result, valid in DONE and held until the next load completes.
- `stall`  out  1: freeze the pipeline registers.
- `sram_addr`  out  SRAM_AW: half-word address.
- `sram_dq_out`  out  16: write data.
- `sram_dq_oe`  out  1: tri-state enable for the DQ pad. The pad lives in the top level.
- `sram_dq_in`  in  16: read data from the pad.
- `sram_we_n`  out  1: active-low write strobe.
- `sram_oe_n`  out  1: active-low output enable.

## Operation
- Word index: `w = (address - ADDR_BASE) >> 2`. Only the low SRAM_AW-1 bits of `w` are used; higher bits wrap silently.
- The LOW phase uses `sram_addr = {w, 1'b0}` and carries data bits [15:0]. The HIGH phase uses `{w, 1'b1}` and carries bits [31:16].
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE → LOW when `MEM_R_En | MEM_W_En`. On this transition, latch the op, `w` and `wdata`.
  - LOW → HIGH after WAIT_CYCLES+1 cycles in LOW.
  - HIGH → DONE after WAIT_CYCLES+1 cycles in HIGH.
  - DONE → IDLE unconditionally.
- A phase-cycle counter (0..WAIT_CYCLES) clears on every phase entry.
- `stall` is combinational:
  - 1 in IDLE when a request is present.
  - 1 throughout LOW and HIGH.
  - 0 in DONE.
  - Forced to 0 while `rst` is asserted.
- Read phase: `sram_oe_n = 0` for the whole phase.
  - LOW: `sram_dq_in` is captured into `rdata[15:0]` at the edge ending the final cycle of the phase.
  - HIGH: captured into `rdata[31:16]` the same way.
- Write phase:
  - `sram_dq_oe = 1` and `sram_dq_out` = the latched half for the whole phase.
  - `sram_we_n = 0` on every phase cycle except the last, which is the hold cycle. With WAIT_CYCLES=0 the strobe is 0 for that single cycle.
- Both enables asserted: the access is treated as a write. `rdata` is unchanged.
- Requests that drop mid-access (flush) do not abort it; the access completes through DONE.
- Requests are not sampled in DONE. A back-to-back request is seen in the following IDLE cycle.
- Outputs in IDLE/DONE: `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`. `sram_addr` holds its last value.

## Timing
- Reset values:
  - state = IDLE
  - `rdata = 0`
  - `sram_addr = 0`
  - `sram_dq_out = 0`
  - `sram_dq_oe = 0`
  - `sram_we_n = 1`
  - `sram_oe_n = 1`
  - `stall = 0`
- Access latency with request in IDLE at cycle 0:
  - LOW occupies cycles 1..W+1; HIGH occupies W+2..2W+2.
  - DONE is cycle 2W+3, where W = WAIT_CYCLES.
  - `stall` is high for 2W+3 cycles; for W=2 that is cycles 0–6, low at 7.
- The pipeline register captures `rdata` at the edge ending DONE.
- Reset asserted mid-access: immediately go to IDLE with the reset values above. The SRAM write is abandoned and may be partial.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum (IDLE, LOW, HIGH, DONE)
  - default constants ADDR_BASE=1024, WAIT_CYCLES=2, SRAM_AW=18
  - width of the phase counter, `$clog2(8)`
- Sub-module `sram_wait_counter`: a clear/enable counter with a terminal-count output `last`. It is instantiated once and shared by both phases.
- The DQ tri-state buffer stays in the top level.

## Test plan
- Store then load:
  - Store 0xDEADBEEF to 0x400 → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
  - Load 0x400 → `rdata`=0xDEADBEEF in DONE.
  - `stall` high for exactly 7 cycles each.
- Address mapping: store 0x12345678 at 0x40C → writes hit half-word addresses 6 and 7. `sram_we_n` low for 2 of 3 cycles per phase.
- Back-to-back: load at 0x404 immediately after a store to 0x408. There is one IDLE cycle with `stall`=1 between them, and the second `rdata` is correct.
- Flush mid-access: drop `MEM_W_En` in cycle 2 of a store. The write still completes and DONE still occurs.
- Reset at cycle 4 of a load: state returns to IDLE at once; outputs equal the reset values and `stall`=0.
- Both enables set with WAIT_CYCLES=0: a write occurs, `rdata` is unchanged, and `stall` is high for 3 cycles.
